fiszero: RTL and testbench

FISZERO -- requirements
Module: fiszero

---
 rtl/fpu_pkg.sv | 18 +
 rtl/fiszero_core.sv | 25 ++
 rtl/fiszero.sv | 88 ++++++++
 tb/tb_fiszero.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared binary32 field positions and constants for the FP helper blocks.
package fpu_pkg;

  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned FRAC_MSB = 22;

  localparam logic [7:0] EXP_ZERO = 8'h00;
  localparam logic [7:0] EXP_MAX  = 8'hFF;

  // One buffered result: zero flag plus the operand that produced it.
  typedef struct packed {
    logic        zero;
    logic [31:0] op;
  } entry_t;

endpackage

// File: rtl/fiszero_core.sv
// Combinational binary32 zero test; FTZ selects whether subnormals count as zero.
module fiszero_core
  import fpu_pkg::*;
#(
  parameter bit FTZ = 1'b1
) (
  input  logic [31:0] op,
  output logic        zero
);

  logic [7:0] w_exp;
  logic       w_exp_zero;
  logic       w_frac_zero;
  logic       w_unused_sign;

  assign w_exp         = op[EXP_MSB:EXP_LSB];
  assign w_exp_zero    = (w_exp == EXP_ZERO) && (w_exp != EXP_MAX);
  assign w_frac_zero   = (op[FRAC_MSB:0] == '0);
  assign w_unused_sign = op[SIGN_BIT];

  always_comb begin
    zero = w_exp_zero & (FTZ ? 1'b1 : w_frac_zero);
  end

endmodule

// File: rtl/fiszero.sv
// Registered zero-test stage: output register plus one-entry skid, valid/ready on both sides.
module fiszero
  import fpu_pkg::*;
#(
  parameter bit FTZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        result,
  output logic [31:0] op_out
);

  entry_t r_out;
  entry_t r_skid;
  logic   r_out_valid;
  logic   r_skid_valid;
  logic   r_in_ready;

  entry_t w_in;
  entry_t w_out_next;
  entry_t w_skid_next;
  logic   w_out_valid_next;
  logic   w_skid_valid_next;
  logic   w_zero;
  logic   w_accept;
  logic   w_pop;

  fiszero_core #(
    .FTZ (FTZ)
  ) u_core (
    .op   (op),
    .zero (w_zero)
  );

  assign w_in     = '{zero: w_zero, op: op};
  assign w_accept = in_valid && r_in_ready;
  assign w_pop    = r_out_valid && out_ready;

  // in_ready is only high while the skid is empty, so an accept never collides with a full skid.
  always_comb begin
    w_out_next        = r_out;
    w_skid_next       = r_skid;
    w_out_valid_next  = r_out_valid;
    w_skid_valid_next = r_skid_valid;
    if (w_pop || !r_out_valid) begin
      if (r_skid_valid) begin
        w_out_next        = r_skid;
        w_out_valid_next  = 1'b1;
        w_skid_valid_next = 1'b0;
      end else begin
        w_out_valid_next = w_accept;
        if (w_accept) begin
          w_out_next = w_in;
        end
      end
    end else if (w_accept) begin
      w_skid_next       = w_in;
      w_skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
    end else begin
      r_out        <= w_out_next;
      r_skid       <= w_skid_next;
      r_out_valid  <= w_out_valid_next;
      r_skid_valid <= w_skid_valid_next;
      r_in_ready   <= ~w_skid_valid_next;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_out.zero;
  assign op_out    = r_out.op;

endmodule

// File: tb/tb_fiszero.sv
// Directed and random checks of fiszero; an FTZ=1 and an FTZ=0 instance share one stimulus.
module tb_fiszero;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] op;
  logic        out_ready;

  logic        in_ready1, out_valid1, result1;
  logic [31:0] op_out1;
  logic        in_ready0, out_valid0, result0;
  logic [31:0] op_out0;

  int n_checks;
  int n_fail;

  fiszero #(
    .FTZ (1'b1)
  ) u_dut_ftz1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .op        (op),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .result    (result1),
    .op_out    (op_out1)
  );

  fiszero #(
    .FTZ (1'b0)
  ) u_dut_ftz0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .op        (op),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .result    (result0),
    .op_out    (op_out0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present v with out_ready=1 for one cycle and check the registered result next cycle.
  task automatic send_check(input string tag, input logic [31:0] v, input logic exp1,
                            input logic exp0);
    in_valid  = 1'b1;
    op        = v;
    out_ready = 1'b1;
    check_val({tag, " in_ready"}, {31'd0, in_ready1}, 32'd1);
    tick();
    in_valid = 1'b0;
    check_val({tag, " out_valid"}, {31'd0, out_valid1}, 32'd1);
    check_val({tag, " op_out"}, op_out1, v);
    check_val({tag, " result ftz1"}, {31'd0, result1}, {31'd0, exp1});
    check_val({tag, " result ftz0"}, {31'd0, result0}, {31'd0, exp0});
  endtask

  logic [31:0] q[$];
  logic [31:0] exp_op;
  logic [31:0] prev_op;
  logic        prev_stall;
  int          sent;
  int          cycles;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 32'h0;
    out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check_val("rst out_valid", {31'd0, out_valid1}, 32'd0);
    check_val("rst in_ready", {31'd0, in_ready1}, 32'd0);
    check_val("rst result", {31'd0, result1}, 32'd0);
    check_val("rst op_out", op_out1, 32'h0);
    rst = 1'b0;
    check_val("rel in_ready low", {31'd0, in_ready1}, 32'd0);
    tick();
    check_val("rel in_ready high", {31'd0, in_ready1}, 32'd1);
    check_val("rel in_ready ftz0", {31'd0, in_ready0}, 32'd1);

    // Back-to-back directed operands
    send_check("pzero", 32'h0000_0000, 1'b1, 1'b1);
    send_check("nzero", 32'h8000_0000, 1'b1, 1'b1);
    send_check("subn min", 32'h0000_0001, 1'b1, 1'b0);
    send_check("nsubn max", 32'h807F_FFFF, 1'b1, 1'b0);
    send_check("norm min", 32'h0080_0000, 1'b0, 1'b0);
    send_check("one", 32'h3F80_0000, 1'b0, 1'b0);
    send_check("inf", 32'h7F80_0000, 1'b0, 1'b0);
    send_check("qnan", 32'h7FC0_0000, 1'b0, 1'b0);
    tick();
    check_val("idle out_valid", {31'd0, out_valid1}, 32'd0);

    // Stall: three offered, two accepted
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = 32'h3F80_0000;
    tick();
    check_val("stall A out_valid", {31'd0, out_valid1}, 32'd1);
    check_val("stall A in_ready", {31'd0, in_ready1}, 32'd1);
    op = 32'h0000_0000;
    tick();
    check_val("stall full in_ready", {31'd0, in_ready1}, 32'd0);
    op = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("stall hold op_out", op_out1, 32'h3F80_0000);
      check_val("stall hold result", {31'd0, result1}, 32'd0);
      check_val("stall hold in_ready", {31'd0, in_ready1}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_val("drain B op_out", op_out1, 32'h0000_0000);
    check_val("drain B result", {31'd0, result1}, 32'd1);
    check_val("drain in_ready", {31'd0, in_ready1}, 32'd1);
    tick();
    check_val("drain empty", {31'd0, out_valid1}, 32'd0);

    // Asynchronous reset with two results buffered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = 32'h4000_0000;
    tick();
    op = 32'h4040_0000;
    tick();
    in_valid = 1'b0;
    check_val("pre-rst out_valid", {31'd0, out_valid1}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("async rst out_valid", {31'd0, out_valid1}, 32'd0);
    check_val("async rst in_ready", {31'd0, in_ready1}, 32'd0);
    check_val("async rst op_out", op_out1, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    send_check("post-rst zero", 32'h0000_0000, 1'b1, 1'b1);
    tick();
    check_val("post-rst empty", {31'd0, out_valid1}, 32'd0);

    // Random traffic against a scoreboard
    sent       = 0;
    cycles     = 0;
    prev_stall = 1'b0;
    prev_op    = 32'h0;
    in_valid   = 1'b1;
    op         = $urandom;
    out_ready  = 1'($urandom_range(0, 1));
    while ((sent < 10000 || q.size() != 0) && cycles < 60000) begin
      if (prev_stall) begin
        check_val("rnd stall valid", {31'd0, out_valid1}, 32'd1);
        check_val("rnd stall op_out", op_out1, prev_op);
      end
      if (out_valid1 && out_ready) begin
        if (q.size() == 0) begin
          check_val("rnd spurious out", {31'd0, out_valid1}, 32'd0);
        end else begin
          exp_op = q.pop_front();
          check_val("rnd op_out", op_out1, exp_op);
          check_val("rnd result ftz1", {31'd0, result1},
                    {31'd0, (exp_op[30:23] == 8'h00)});
          check_val("rnd result ftz0", {31'd0, result0},
                    {31'd0, (exp_op[30:0] == 31'h0)});
        end
      end
      if (in_valid && in_ready1) begin
        q.push_back(op);
        sent++;
      end
      prev_stall = out_valid1 && !out_ready;
      prev_op    = op_out1;
      tick();
      cycles++;
      in_valid = (sent < 10000);
      op       = $urandom;
      if ($urandom_range(0, 7) == 0) op[30:23] = 8'h00;
      if ($urandom_range(0, 15) == 0) op[22:0] = 23'h0;
      out_ready = 1'($urandom_range(0, 1));
    end
    check_val("rnd all sent", sent, 10000);
    check_val("rnd none left", q.size(), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_val("rnd final empty", {31'd0, out_valid1}, 32'd0);
    check_val("rnd final in_ready", {31'd0, in_ready1}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
